// File: rtl/host_rd_data_demux_pkg.sv
// Shared definitions for the host read data demultiplexer: default
// configuration, the ordering-entry layout and small sizing helpers.
package host_rd_data_demux_pkg;

    localparam int DEF_N_ID      = 4;
    localparam int DEF_DATA_BITS = 512;
    localparam int DEF_LEN_BITS  = 28;
    localparam int DEF_QDEPTH    = 16;

    // Width of a region id; a single region still needs one id bit.
    function automatic int id_bits(input int n_id);
        return (n_id > 1) ? $clog2(n_id) : 1;
    endfunction

    // Bytes carried by one data beat.
    function automatic int beat_bytes(input int data_bits);
        return data_bits / 8;
    endfunction

    localparam int DEF_ID_BITS    = id_bits(DEF_N_ID);
    localparam int DEF_BEAT_BYTES = beat_bytes(DEF_DATA_BITS);

    // Ordering entry as emitted by the host read arbiter (default sizing).
    typedef struct packed {
        logic [DEF_ID_BITS-1:0]  id;
        logic [DEF_LEN_BITS-1:0] len;
    } mux_entry_t;

    localparam int MUX_ENTRY_BITS = $bits(mux_entry_t);

endpackage

// File: rtl/host_rd_data_demux_order_queue.sv
// host_rd_order_queue: show-ahead FIFO of ordering entries. The head entry
// is visible combinationally so the consumer can inspect it and pop in the
// same cycle; a pop frees its slot for a push in that very cycle.
module host_rd_order_queue
    import host_rd_data_demux_pkg::*;
#(
    parameter int WIDTH = MUX_ENTRY_BITS,
    parameter int DEPTH = DEF_QDEPTH
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Small storage read asynchronously so the head is available the cycle
    // after it was written.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr_reg[AW-1:0]];

    // Entry storage write.
    always_ff @(posedge aclk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Read/write pointers with a wrap bit to tell full from empty.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/host_rd_data_demux.sv
// host_rd_data_demux: steers the returning host read data stream to the
// per-region output streams in grant order, using the (id, len) ordering
// entries produced by the host read arbiter.
// Optional feature: define HOST_RD_DEMUX_TLAST_CHECK_EN to compare the
// upstream tlast against the computed entry end and raise sticky err_tlast.
module host_rd_data_demux
    import host_rd_data_demux_pkg::*;
#(
    parameter int N_ID      = DEF_N_ID,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int LEN_BITS  = DEF_LEN_BITS,
    parameter int QDEPTH    = DEF_QDEPTH
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           s_mux_valid,
    output logic                           s_mux_ready,
    input  logic [id_bits(N_ID)-1:0]       s_mux_id,
    input  logic [LEN_BITS-1:0]            s_mux_len,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic [DATA_BITS-1:0]           s_axis_tdata,
    input  logic [DATA_BITS/8-1:0]         s_axis_tkeep,
    input  logic                           s_axis_tlast,
    output logic [N_ID-1:0]                m_axis_tvalid,
    input  logic [N_ID-1:0]                m_axis_tready,
    output logic [N_ID*DATA_BITS-1:0]      m_axis_tdata,
    output logic [N_ID*(DATA_BITS/8)-1:0]  m_axis_tkeep,
    output logic [N_ID-1:0]                m_axis_tlast,
    output logic                           err_tlast
);

    localparam int ID_BITS    = id_bits(N_ID);
    localparam int BEAT_BYTES = beat_bytes(DATA_BITS);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    typedef struct packed {
        logic [ID_BITS-1:0]  id;
        logic [LEN_BITS-1:0] len;
    } entry_t;

    localparam int ENTRY_BITS = $bits(entry_t);

    entry_t               push_entry;
    entry_t               head_entry;
    logic                 q_full;
    logic                 q_empty;
    logic                 q_pop;
    logic [LEN_BITS:0]    len_round;
    logic [LEN_BITS-1:0]  head_beats;
    logic                 head_loadable;

    logic [0:0]           state_reg, state_next;
    logic [ID_BITS-1:0]   id_reg, id_next;
    logic [LEN_BITS-1:0]  cnt_reg, cnt_next;
    logic                 xfer;
    logic                 cnt_zero;
    logic                 s_hs;

    assign push_entry  = '{id: s_mux_id, len: s_mux_len};
    // A pop in this cycle makes room for the incoming entry.
    assign s_mux_ready = !q_full || q_pop;

    host_rd_order_queue #(
        .WIDTH (ENTRY_BITS),
        .DEPTH (QDEPTH)
    ) u_order_queue (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (s_mux_valid),
        .push_data (push_entry),
        .pop       (q_pop),
        .head      (head_entry),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Beats for the head entry: ceil(len / BEAT_BYTES), one extra bit to
    // keep the rounding add from overflowing.
    assign len_round     = {1'b0, head_entry.len} + (LEN_BITS+1)'(BEAT_BYTES - 1);
    assign head_beats    = LEN_BITS'(len_round / (LEN_BITS+1)'(BEAT_BYTES));
    assign head_loadable = !q_empty && (head_beats != '0);

    assign xfer     = (state_reg == ST_XFER);
    assign cnt_zero = (cnt_reg == '0);
    assign s_hs     = s_axis_tvalid && s_axis_tready;

    // Next-state logic: load entries, count beats, chain entries without a bubble.
    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        cnt_next   = cnt_reg;
        q_pop      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!q_empty) begin
                    // Zero-length entries are consumed here without routing.
                    q_pop = 1'b1;
                    if (head_beats != '0) begin
                        id_next    = head_entry.id;
                        cnt_next   = head_beats - LEN_BITS'(1);
                        state_next = ST_XFER;
                    end
                end
            end
            ST_XFER: begin
                if (s_hs) begin
                    if (cnt_zero) begin
                        if (head_loadable) begin
                            q_pop    = 1'b1;
                            id_next  = head_entry.id;
                            cnt_next = head_beats - LEN_BITS'(1);
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        cnt_next = cnt_reg - LEN_BITS'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM, active region and remaining-beat counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg <= ST_IDLE;
            id_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            id_reg    <= id_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Upstream is only accepted while an entry is active.
    assign s_axis_tready = xfer ? m_axis_tready[id_reg] : 1'b0;

    genvar gi;
    generate
        for (gi = 0; gi < N_ID; gi++) begin : g_region
            logic sel;
            assign sel               = xfer && (id_reg == ID_BITS'(gi));
            assign m_axis_tvalid[gi] = sel && s_axis_tvalid;
            assign m_axis_tlast[gi]  = sel && cnt_zero;
            assign m_axis_tdata[gi*DATA_BITS +: DATA_BITS]    = s_axis_tdata;
            assign m_axis_tkeep[gi*BEAT_BYTES +: BEAT_BYTES]  = s_axis_tkeep;
        end
    endgenerate

`ifdef HOST_RD_DEMUX_TLAST_CHECK_EN
    logic err_tlast_reg;

    // Sticky flag when upstream tlast disagrees with the computed entry end.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_tlast_reg <= 1'b0;
        end else if (s_hs && (s_axis_tlast != cnt_zero)) begin
            err_tlast_reg <= 1'b1;
        end
    end

    assign err_tlast = err_tlast_reg;
`else
    logic tlast_unused;
    assign tlast_unused = s_axis_tlast;
    assign err_tlast    = 1'b0;
`endif

endmodule

// File: tb/tb_host_rd_data_demux.sv
// Scoreboard bench for host_rd_data_demux: entries are modelled as beat
// lists pushed into an expected queue; a monitor pops on every output beat.
module tb_host_rd_data_demux;

    localparam int N_ID      = 4;
    localparam int DATA_BITS = 512;
    localparam int BB        = DATA_BITS / 8;
    localparam int LEN_BITS  = 28;
    localparam int QDEPTH    = 16;
    localparam int ID_BITS   = 2;
    localparam int NTAB      = 2048;

`ifdef HOST_RD_DEMUX_TLAST_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic                      aclk = 1'b0;
    logic                      aresetn;
    logic                      s_mux_valid;
    logic                      s_mux_ready;
    logic [ID_BITS-1:0]        s_mux_id;
    logic [LEN_BITS-1:0]       s_mux_len;
    logic                      s_axis_tvalid;
    logic                      s_axis_tready;
    logic [DATA_BITS-1:0]      s_axis_tdata;
    logic [BB-1:0]             s_axis_tkeep;
    logic                      s_axis_tlast;
    logic [N_ID-1:0]           m_axis_tvalid;
    logic [N_ID-1:0]           m_axis_tready;
    logic [N_ID*DATA_BITS-1:0] m_axis_tdata;
    logic [N_ID*BB-1:0]        m_axis_tkeep;
    logic [N_ID-1:0]           m_axis_tlast;
    logic                      err_tlast;

    host_rd_data_demux #(
        .N_ID      (N_ID),
        .DATA_BITS (DATA_BITS),
        .LEN_BITS  (LEN_BITS),
        .QDEPTH    (QDEPTH)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_mux_valid   (s_mux_valid),
        .s_mux_ready   (s_mux_ready),
        .s_mux_id      (s_mux_id),
        .s_mux_len     (s_mux_len),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .err_tlast     (err_tlast)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int                   id;
        bit                   last;
        int                   idx;
        logic [DATA_BITS-1:0] data;
        logic [BB-1:0]        keep;
    } exp_t;

    exp_t                 exp_q[$];
    logic [DATA_BITS-1:0] data_tab [NTAB];
    logic [BB-1:0]        keep_tab [NTAB];
    bit                   up_last  [NTAB];

    int          total_beats = 0;
    int          up_k        = 0;
    int          inject_k    = -1;
    int          up_prob     = 100;
    int          ds_prob     = 100;
    bit          up_en       = 1'b0;
    logic [N_ID-1:0] ds_block = '0;
    bit          hs_seen     = 1'b0;
    bit          err_watch   = 1'b0;
    int          n_cmp       = 0;
    int          n_bad       = 0;
    int          nhs;
    exp_t        mon_e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_wide(input string nm, input logic [DATA_BITS-1:0] act,
                            input logic [DATA_BITS-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: an entry becomes ceil(len/BB) beats, last flag on the final one.
    task automatic model_push(input int id, input int len);
        int beats;
        exp_t e;
        beats = (len + BB - 1) / BB;
        for (int b = 0; b < beats; b++) begin
            e.id   = id;
            e.last = (b == beats - 1);
            e.idx  = total_beats;
            e.data = data_tab[total_beats % NTAB];
            e.keep = keep_tab[total_beats % NTAB];
            up_last[total_beats % NTAB] = e.last;
            exp_q.push_back(e);
            total_beats++;
        end
        $display("entry id=%0d len=%0d beats=%0d", id, len, beats);
    endtask

    task automatic push_entry(input int id, input int len, input int max_wait, output bit ok);
        ok = 1'b0;
        @(posedge aclk); #1;
        s_mux_valid = 1'b1;
        s_mux_id    = ID_BITS'(id);
        s_mux_len   = LEN_BITS'(len);
        for (int c = 0; c < max_wait; c++) begin
            @(negedge aclk);
            if (s_mux_ready) begin
                ok = 1'b1;
                model_push(id, len);
                break;
            end
            if (c < max_wait - 1) begin
                @(posedge aclk); #1;
            end
        end
    endtask

    task automatic mux_idle();
        @(posedge aclk); #1;
        s_mux_valid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int c = 0;
        while (exp_q.size() != 0 && c < bound) begin
            @(negedge aclk);
            c++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge aclk);
    endtask

    // Upstream handshake sampler.
    initial begin
        forever begin
            @(negedge aclk);
            hs_seen = aresetn && s_axis_tvalid && s_axis_tready;
        end
    end

    // Upstream source: beat k carries data_tab[k]; valid held until accepted.
    initial begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        forever begin
            @(posedge aclk); #2;
            if (!aresetn) begin
                s_axis_tvalid = 1'b0;
                up_k = total_beats;
            end else begin
                if (hs_seen) begin
                    up_k++;
                    s_axis_tvalid = 1'b0;
                end
                if (!up_en) begin
                    s_axis_tvalid = 1'b0;
                end else if (!s_axis_tvalid) begin
                    s_axis_tvalid = ($urandom_range(0, 99) < up_prob);
                end
            end
            s_axis_tdata = data_tab[up_k % NTAB];
            s_axis_tkeep = keep_tab[up_k % NTAB];
            s_axis_tlast = up_last[up_k % NTAB] ^ (up_k == inject_k);
        end
    end

    // Downstream sinks with random backpressure plus directed blocking.
    initial begin
        m_axis_tready = '0;
        forever begin
            @(posedge aclk); #2;
            for (int i = 0; i < N_ID; i++) begin
                m_axis_tready[i] = ($urandom_range(0, 99) < ds_prob) && !ds_block[i];
            end
        end
    end

    // Monitor: every output beat is popped from the scoreboard and compared.
    initial begin
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                nhs = 0;
                if (err_watch) begin
                    chk("err_tlast_next", 64'(err_tlast), 64'(EXP_ERR));
                    err_watch = 1'b0;
                end
                if (m_axis_tvalid != '0) begin
                    chk("valid_onehot", 64'($countones(m_axis_tvalid) <= 1), 64'd1);
                end
                for (int i = 0; i < N_ID; i++) begin
                    if (m_axis_tvalid[i] && m_axis_tready[i]) begin
                        nhs++;
                        if (exp_q.size() == 0) begin
                            chk("unexpected_beat", 64'(i + 1), 64'd0);
                        end else begin
                            mon_e = exp_q.pop_front();
                            $display("beat %0d region=%0d last=%0b", mon_e.idx, i, m_axis_tlast[i]);
                            chk("beat_region", 64'(i), 64'(mon_e.id));
                            chk("beat_last", 64'(m_axis_tlast[i]), 64'(mon_e.last));
                            chk_wide("beat_data", m_axis_tdata[i*DATA_BITS +: DATA_BITS], mon_e.data);
                            chk("beat_keep", 64'(m_axis_tkeep[i*BB +: BB]), 64'(mon_e.keep));
                            if (mon_e.idx == inject_k) begin
                                chk("err_tlast_before", 64'(err_tlast), 64'd0);
                                err_watch = 1'b1;
                            end
                        end
                    end
                end
                if (nhs != 0 || (s_axis_tvalid && s_axis_tready)) begin
                    chk("hs_pairing", 64'(nhs), 64'(s_axis_tvalid && s_axis_tready));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int nacc;
        int last_id;
        for (int k = 0; k < NTAB; k++) begin
            for (int w = 0; w < DATA_BITS / 32; w++) begin
                data_tab[k][w*32 +: 32] = $urandom;
            end
            keep_tab[k] = {$urandom, $urandom};
            up_last[k]  = 1'b0;
        end
        aresetn     = 1'b0;
        s_mux_valid = 1'b0;
        s_mux_id    = '0;
        s_mux_len   = '0;

        // Reset state
        repeat (3) @(negedge aclk);
        chk("rst_mux_ready", 64'(s_mux_ready), 64'd1);
        chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_err", 64'(err_tlast), 64'd0);
        #2 aresetn = 1'b1;
        up_en = 1'b1;
        repeat (3) @(negedge aclk);

        // Single entry id=2 len=128: routing starts two cycles after acceptance
        push_entry(2, 128, 10, ok);
        chk("t1_accept", 64'(ok), 64'd1);
        mux_idle();
        @(negedge aclk);
        chk("t1_n1_tready", 64'(s_axis_tready), 64'd0);
        chk("t1_n1_valid", 64'(m_axis_tvalid), 64'd0);
        @(negedge aclk);
        chk("t1_n2_tready", 64'(s_axis_tready), 64'd1);
        chk("t1_n2_valid", 64'(m_axis_tvalid), 64'(4'b0100));
        chk("t1_n2_last", 64'(m_axis_tlast), 64'd0);
        @(negedge aclk);
        chk("t1_n3_valid", 64'(m_axis_tvalid), 64'(4'b0100));
        chk("t1_n3_last", 64'(m_axis_tlast), 64'(4'b0100));
        wait_drain(200);

        // Back-to-back entries: no bubble at the entry boundary
        push_entry(0, 64, 10, ok);
        push_entry(3, 192, 10, ok);
        mux_idle();
        @(negedge aclk);
        chk("t2_b0_valid", 64'(m_axis_tvalid), 64'(4'b0001));
        chk("t2_b0_last", 64'(m_axis_tlast), 64'(4'b0001));
        chk("t2_b0_hs", 64'(s_axis_tvalid && s_axis_tready), 64'd1);
        for (int b = 0; b < 3; b++) begin
            @(negedge aclk);
            chk("t2_valid", 64'(m_axis_tvalid), 64'(4'b1000));
            chk("t2_hs", 64'(s_axis_tvalid && s_axis_tready), 64'd1);
            chk("t2_last", 64'(m_axis_tlast), (b == 2) ? 64'(4'b1000) : 64'd0);
        end
        wait_drain(200);

        // Rounding and zero-length discard
        push_entry(1, 100, 10, ok);
        push_entry(2, 0, 10, ok);
        push_entry(0, 64, 10, ok);
        mux_idle();
        wait_drain(200);

        // Downstream stall on region 1 for five cycles
        push_entry(1, 640, 10, ok);
        mux_idle();
        @(negedge aclk);
        @(negedge aclk);
        for (int s = 0; s < 5; s++) begin
            @(posedge aclk); #1;
            ds_block = 4'b0010;
            @(negedge aclk);
            chk("t4_stall_tready", 64'(s_axis_tready), 64'd0);
            chk("t4_stall_valid", 64'(m_axis_tvalid[1]), 64'd1);
        end
        @(posedge aclk); #1;
        ds_block = '0;
        @(negedge aclk);
        chk("t4_resume_tready", 64'(s_axis_tready), 64'd1);
        wait_drain(200);

        // Randomized traffic
        up_prob = 70;
        ds_prob = 70;
        for (int n = 0; n < 80; n++) begin
            push_entry($urandom_range(0, N_ID - 1),
                       ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 400), 200, ok);
            if (!ok) chk("push_timeout", 64'd0, 64'd1);
            if ($urandom_range(0, 3) == 0) begin
                mux_idle();
                repeat ($urandom_range(0, 3)) @(negedge aclk);
            end
        end
        mux_idle();
        wait_drain(4000);

        // Fill the queue with upstream stalled; one entry is active, QDEPTH queued
        up_prob = 100;
        ds_prob = 100;
        up_en   = 1'b0;
        repeat (4) @(negedge aclk);
        nacc = 0;
        ok   = 1'b1;
        while (ok && nacc < 40) begin
            last_id = $urandom_range(0, N_ID - 1);
            push_entry(last_id, 64, 1, ok);
            if (ok) nacc++;
        end
        chk("t5_fill_count", 64'(nacc), 64'(QDEPTH + 1));
        chk("t5_full_ready", 64'(s_mux_ready), 64'd0);
        up_en = 1'b1;
        @(negedge aclk);
        chk("t5_pop_hs", 64'(s_axis_tvalid && s_axis_tready), 64'd1);
        chk("t5_ready_on_pop", 64'(s_mux_ready), 64'd1);
        if (s_mux_ready) model_push(last_id, 64);
        mux_idle();
        wait_drain(400);

        // Upstream tlast asserted on beat 1 of a 2-beat entry
        chk("t6_err_pre", 64'(err_tlast), 64'd0);
        inject_k = total_beats;
        push_entry(0, 128, 10, ok);
        mux_idle();
        wait_drain(200);
        repeat (3) @(negedge aclk);
        chk("t6_err_sticky", 64'(err_tlast), 64'(EXP_ERR));

        // Reset in the middle of a transfer
        push_entry(3, 640, 10, ok);
        mux_idle();
        repeat (4) @(negedge aclk);
        #2 aresetn = 1'b0;
        #1;
        chk("t7_s_tready", 64'(s_axis_tready), 64'd0);
        chk("t7_m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("t7_m_tlast", 64'(m_axis_tlast), 64'd0);
        chk("t7_mux_ready", 64'(s_mux_ready), 64'd1);
        chk("t7_err", 64'(err_tlast), 64'd0);
        exp_q.delete();
        inject_k = -1;
        @(negedge aclk);
        @(negedge aclk);
        #2 aresetn = 1'b1;

        // Traffic after reset
        up_prob = 80;
        ds_prob = 80;
        for (int n = 0; n < 10; n++) begin
            push_entry($urandom_range(0, N_ID - 1), $urandom_range(0, 300), 200, ok);
            if (!ok) chk("push_timeout2", 64'd0, 64'd1);
        end
        mux_idle();
        wait_drain(2000);
        chk("final_err", 64'(err_tlast), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
